// File: rtl/alu_arbiter_2req.sv
// Shares one external 4-bit ALU between two valid/ready requesters.
// Round-robin grant, operands held for a per-opcode latency, result and flags registered.
module alu_arbiter_2req #(
   parameter int unsigned MULDIV_LAT = 2,
   parameter int unsigned BASE_LAT   = 1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_valid_i,
   output logic [1:0] req_ready_o,
   input  logic [3:0] req0_a_i,
   input  logic [3:0] req0_b_i,
   input  logic [3:0] req0_sel_i,
   input  logic [3:0] req1_a_i,
   input  logic [3:0] req1_b_i,
   input  logic [3:0] req1_sel_i,
   output logic [3:0] alu_a_o,
   output logic [3:0] alu_b_o,
   output logic [3:0] alu_sel_o,
   input  logic [3:0] alu_out_i,
   input  logic [3:0] alu_flags_i,
   output logic [1:0] rsp_valid_o,
   input  logic [1:0] rsp_ready_i,
   output logic [3:0] rsp_data_o,
   output logic [3:0] rsp_flags_o,
   output logic       busy_o
);

   localparam int unsigned MaxLat = (MULDIV_LAT > BASE_LAT) ? MULDIV_LAT : BASE_LAT;
   localparam int unsigned CntW   = $clog2(MaxLat) + 1;
   localparam logic [CntW-1:0] MulDivCnt = CntW'(MULDIV_LAT - 1);
   localparam logic [CntW-1:0] BaseCnt   = CntW'(BASE_LAT - 1);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]      a_q, a_d;
   logic [3:0]      b_q, b_d;
   logic [3:0]      sel_q, sel_d;
   logic [3:0]      data_q, data_d;
   logic [3:0]      flags_q, flags_d;
   logic            owner_q, owner_d;
   logic            last_q, last_d;
   logic            grant;
   logic [3:0]      grant_sel;

   // On a tie the requester not served last wins.
   always_comb begin
      unique case (req_valid_i)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_q;
         default: grant = 1'b0;
      endcase
   end

   assign grant_sel = grant ? req1_sel_i : req0_sel_i;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      sel_d       = sel_q;
      data_d      = data_q;
      flags_d     = flags_q;
      owner_d     = owner_q;
      last_d      = last_q;
      req_ready_o = 2'b00;
      rsp_valid_o = 2'b00;
      unique case (state_q)
         StIdle: begin
            if (|req_valid_i) begin
               req_ready_o[grant] = 1'b1;
               a_d     = grant ? req1_a_i : req0_a_i;
               b_d     = grant ? req1_b_i : req0_b_i;
               sel_d   = grant_sel;
               owner_d = grant;
               cnt_d   = (grant_sel == 4'b0010 || grant_sel == 4'b0011) ? MulDivCnt : BaseCnt;
               state_d = StExec;
            end
         end
         StExec: begin
            if (cnt_q == '0) begin
               data_d  = alu_out_i;
               flags_d = alu_flags_i;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StResp: begin
            rsp_valid_o[owner_q] = 1'b1;
            if (rsp_ready_i[owner_q]) begin
               last_d  = owner_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sel_q   <= '0;
         data_q  <= '0;
         flags_q <= '0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         flags_q <= flags_d;
         owner_q <= owner_d;
         last_q  <= last_d;
      end
   end

   assign alu_a_o     = a_q;
   assign alu_b_o     = b_q;
   assign alu_sel_o   = sel_q;
   assign rsp_data_o  = data_q;
   assign rsp_flags_o = flags_q;
   assign busy_o      = (state_q != StIdle);

endmodule
